// File: rtl/psum_rearrange_pkg.sv
// Shared definitions for the psum rearrange buffer (reader and writer sides).
// Latency: n/a (types, constants and a config helper only).
// Backpressure: n/a.
//
// Contents: buffer geometry constants, controller state encoding, the
// {last, data} element carried through the reader's skid FIFO, and the
// frame-volume helpers used to validate a start request.
package psum_rearrange_pkg;

  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 8;
  localparam int BUFFER_DEPTH = 3500;
  localparam int CLEAR_CYCLES = 4096;
  localparam int FIFO_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_CLEAR_WAIT = 2'd0,
    ST_IDLE       = 2'd1,
    ST_RUN        = 2'd2,
    ST_DRAIN      = 2'd3
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } elem_t;

  // C*H*W; 15*63*63 is the largest value the port widths allow, fits 17 bits.
  function automatic logic [16:0] cfg_volume(input logic [5:0] w,
                                             input logic [5:0] h,
                                             input logic [3:0] c);
    return 17'(w) * 17'(h) * 17'(c);
  endfunction

  function automatic logic cfg_ok(input logic [5:0] w,
                                  input logic [5:0] h,
                                  input logic [3:0] c);
    return (w != 6'd0) && (h != 6'd0) && (c != 4'd0) &&
           (cfg_volume(w, h, c) <= 17'(BUFFER_DEPTH));
  endfunction

endpackage

// File: rtl/psum_reader_skid_fifo.sv
// Two-entry skid FIFO holding {last, data} elements between the read pipe and the stream port.
// Latency: a pushed element is visible at o_head_dat / o_count the cycle after the push.
// Backpressure: push is dropped only when full without a same-cycle pop; caller keeps it from happening.
//
// Ports:
//   i_clock, i_reset   clock, synchronous active-low reset
//   i_push, i_push_dat write strobe and element
//   i_pop              consume the head element (ignored when empty)
//   o_head_dat         current head element (registered storage)
//   o_count            occupancy 0..2
module psum_reader_skid_fifo
  import psum_rearrange_pkg::*;
#(
  parameter int WIDTH = DATA_W + 1
)
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & (r_count != 2'd0);
  // A full FIFO may still accept when the head leaves in the same cycle.
  assign w_do_push = i_push & ((r_count != 2'd2) | w_do_pop);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/psum_rearrange_reader.sv
// Read-side master of the psum rearrange buffer: raster-scans C x Hp x Wp, inserts zero border, streams bytes.
// Latency: start at edge k -> first rd_addr in cycle k+1 -> first out_valid in cycle k+3; 1 elem/cycle sustained.
// Backpressure: out_ready low stalls slot issue once FIFO + in-flight reaches 2; nothing is dropped.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-low reset (restarts the clear wait)
//   i_start, i_cfg_*        frame request and geometry (W, H, C, pad enable), sampled in IDLE
//   o_rd_addr, i_rd_data    buffer read port; data returns one cycle after the address
//   o_out_data/_valid/_last valid/ready element stream, i_out_ready from the consumer
//   o_busy, o_done          activity flag, one-cycle frame-complete pulse
//   o_cfg_err               one-cycle pulse when a start is rejected
module psum_rearrange_reader
  import psum_rearrange_pkg::*;
(
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [5:0]               i_cfg_width,
  input  logic [5:0]               i_cfg_height,
  input  logic [3:0]               i_cfg_channels,
  input  logic                     i_cfg_pad_en,
  output logic [ADDR_W-1:0]        o_rd_addr,
  input  logic [DATA_W-1:0]        i_rd_data,
  output logic signed [DATA_W-1:0] o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_out_last,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_cfg_err
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

  state_t            r_state;
  logic [CLR_W-1:0]  r_clr_cnt;
  logic [5:0]        r_w;
  logic [5:0]        r_h;
  logic [3:0]        r_c;
  logic              r_pad;
  logic [6:0]        r_x;
  logic [6:0]        r_y;
  logic [3:0]        r_ch;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_final_addr;
  logic              r_infl;
  logic              r_infl_pad;
  logic              r_infl_last;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;

  logic [6:0]        w_wp;
  logic [6:0]        w_hp;
  logic              w_x_end;
  logic              w_y_end;
  logic              w_c_end;
  logic              w_last_slot;
  logic              w_pad_slot;
  logic [1:0]        w_fifo_count;
  elem_t             w_head;
  elem_t             w_push_elem;
  logic              w_pop;
  logic              w_issue;
  logic [16:0]       w_vol;

  // Padded extents: the border is at most one element, so x<p / x>=W+p
  // reduce to the first and last column (same for rows).
  assign w_wp        = {1'b0, r_w} + {5'd0, r_pad, 1'b0};
  assign w_hp        = {1'b0, r_h} + {5'd0, r_pad, 1'b0};
  assign w_x_end     = (r_x == w_wp - 7'd1);
  assign w_y_end     = (r_y == w_hp - 7'd1);
  assign w_c_end     = (r_ch == r_c - 4'd1);
  assign w_last_slot = w_x_end & w_y_end & w_c_end;
  assign w_pad_slot  = r_pad & ((r_x == 7'd0) | w_x_end | (r_y == 7'd0) | w_y_end);

  assign o_out_valid = (w_fifo_count != 2'd0);
  assign w_pop       = o_out_valid & i_out_ready;

  // Occupancy after this cycle's pop, plus the slot already in the read
  // pipe, must leave room for the slot issued now.
  assign w_issue = (r_state == ST_RUN) &
                   (({1'b0, w_fifo_count} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop}));

  // Pad slots ride the same one-cycle pipe as reads so ordering is kept.
  assign w_push_elem.last = r_infl_last;
  assign w_push_elem.data = r_infl_pad ? '0 : i_rd_data;

  assign w_vol = cfg_volume(i_cfg_width, i_cfg_height, i_cfg_channels);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= ST_CLEAR_WAIT;
      r_clr_cnt    <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_c          <= '0;
      r_pad        <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_ch         <= '0;
      r_rd_addr    <= '0;
      r_final_addr <= '0;
      r_infl       <= 1'b0;
      r_infl_pad   <= 1'b0;
      r_infl_last  <= 1'b0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_infl    <= w_issue;
      case (r_state)
        ST_CLEAR_WAIT: begin
          if (r_clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (i_start) begin
            if (cfg_ok(i_cfg_width, i_cfg_height, i_cfg_channels)) begin
              r_w          <= i_cfg_width;
              r_h          <= i_cfg_height;
              r_c          <= i_cfg_channels;
              r_pad        <= i_cfg_pad_en;
              r_x          <= '0;
              r_y          <= '0;
              r_ch         <= '0;
              r_rd_addr    <= '0;
              r_final_addr <= ADDR_W'(w_vol - 17'd1);
              r_state      <= ST_RUN;
              r_busy       <= 1'b1;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_infl_pad  <= w_pad_slot;
            r_infl_last <= w_last_slot;
            // Channel planes and rows are stored back to back, so the
            // read address of c*H*W + row*W + col is just a running count
            // of reads. It parks on the final address once that is issued.
            if (!w_pad_slot && (r_rd_addr != r_final_addr)) begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
            if (w_x_end) begin
              r_x <= '0;
              if (w_y_end) begin
                r_y <= '0;
                if (w_c_end) begin
                  r_state <= ST_DRAIN;
                end else begin
                  r_ch <= r_ch + 1'b1;
                end
              end else begin
                r_y <= r_y + 1'b1;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // The tagged last element is the final one; once it leaves, the
          // pipe and FIFO are necessarily empty.
          if (w_pop && w_head.last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_CLEAR_WAIT;
      endcase
    end
  end

  psum_reader_skid_fifo #(
    .WIDTH ($bits(elem_t))
  ) u_skid_fifo (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_push     (r_infl),
    .i_push_dat (w_push_elem),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_fifo_count)
  );

  assign o_rd_addr  = r_rd_addr;
  assign o_out_data = w_head.data;
  assign o_out_last = w_head.last;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_psum_rearrange_reader.sv
// Directed bench for psum_rearrange_reader with a one-cycle-latency buffer model.
// Latency: checks first element at start+3 and done one cycle after the last accept.
// Backpressure: drives out_ready constant or random and checks stall stability.
module tb_psum_rearrange_reader;
  import psum_rearrange_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start;
  logic [5:0]        cfg_w;
  logic [5:0]        cfg_h;
  logic [3:0]        cfg_c;
  logic              cfg_pad;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              cfg_err;

  logic [DATA_W-1:0] bram [0:4095];
  logic [DATA_W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int last_cycles;

  psum_rearrange_reader dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_start        (start),
    .i_cfg_width    (cfg_w),
    .i_cfg_height   (cfg_h),
    .i_cfg_channels (cfg_c),
    .i_cfg_pad_en   (cfg_pad),
    .o_rd_addr      (rd_addr),
    .i_rd_data      (rd_data),
    .o_out_data     (out_data),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_last     (out_last),
    .o_busy         (busy),
    .o_done         (done),
    .o_cfg_err      (cfg_err)
  );

  // Synchronous-read buffer: data for the address seen at an edge appears after it.
  always @(posedge clk) rd_data <= bram[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the next edge, returns one negedge later.
  task automatic pulse_start(input int w, input int h, input int c, input logic pad);
    cfg_w   = 6'(w);
    cfg_h   = 6'(h);
    cfg_c   = 4'(c);
    cfg_pad = pad;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic exp_ramp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(8'(i & 'h7F));
  endtask

  task automatic collect(input int n, input int pct, input string tag);
    int got, cyc, first, last, viol;
    logic held, hl;
    logic [DATA_W-1:0] hd;
    got = 0; cyc = 0; first = -1; last = 0; viol = 0;
    held = 1'b0; hl = 1'b0; hd = '0;
    while (got < n && cyc < n * 8 + 64) begin
      @(negedge clk);
      cyc++;
      out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (held && (!out_valid || out_data !== hd || out_last !== hl)) viol++;
      held = out_valid && !out_ready;
      hd   = out_data;
      hl   = out_last;
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        last = cyc;
        check({tag, "_data"}, 32'(out_data), 32'(exp_q[got]));
        check({tag, "_last"}, 32'(out_last), 32'(got == n - 1));
        got++;
      end
    end
    out_ready = 1'b1;
    check({tag, "_count"}, got, n);
    check({tag, "_stall_stable"}, viol, 0);
    last_cycles = (first < 0) ? 0 : last - first + 1;
  endtask

  initial begin
    logic err_seen, val_seen;
    rst_n = 1'b0; start = 1'b0; cfg_w = '0; cfg_h = '0; cfg_c = '0;
    cfg_pad = 1'b0; out_ready = 1'b1;
    for (int a = 0; a < 4096; a++) bram[a] = 8'(a & 'h7F);

    // Reset values
    tick(3);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);

    // Start during the clear wait is ignored silently
    rst_n = 1'b1;
    tick(99);
    pulse_start(4, 3, 2, 0);
    err_seen = 1'b0; val_seen = 1'b0;
    repeat (8) begin
      err_seen |= cfg_err;
      val_seen |= out_valid;
      @(negedge clk);
    end
    check("clear_no_cfg_err", err_seen, 0);
    check("clear_no_valid", val_seen, 0);
    tick(CLEAR_CYCLES - 10 - 108);
    check("clear_busy", busy, 1);
    tick(14);
    check("idle_busy", busy, 0);

    // 4x3x2 frame, no pad, out_ready high
    exp_ramp(24);
    pulse_start(4, 3, 2, 0);
    check("A_rd_addr0", rd_addr, 0);
    check("A_busy", busy, 1);
    check("A_cfg_err", cfg_err, 0);
    tick(1);
    check("A_no_valid_k2", out_valid, 0);
    collect(24, 100, "A");
    check("A_throughput", last_cycles, 24);
    tick(1);
    check("A_done", done, 1);
    check("A_valid_after", out_valid, 0);
    tick(1);
    check("A_done_pulse", done, 0);
    check("A_idle", busy, 0);
    check("A_rd_addr_end", rd_addr, 23);

    // Same frame, out_ready random at 30%
    exp_ramp(24);
    pulse_start(4, 3, 2, 0);
    collect(24, 30, "B");
    tick(1);
    check("B_done", done, 1);

    // Rejected configurations
    pulse_start(24, 24, 8, 0);
    check("C_big_err", cfg_err, 1);
    check("C_big_busy", busy, 0);
    check("C_big_rd_addr", rd_addr, 23);
    tick(1);
    check("C_err_pulse", cfg_err, 0);
    check("C_big_no_valid", out_valid, 0);
    pulse_start(0, 3, 2, 0);
    check("C_w0_err", cfg_err, 1);
    tick(1);
    pulse_start(27, 26, 5, 0);
    check("C_3510_err", cfg_err, 1);
    tick(1);

    // Exactly BUFFER_DEPTH elements is accepted
    exp_ramp(3500);
    pulse_start(25, 20, 7, 0);
    check("D_cfg_err", cfg_err, 0);
    check("D_busy", busy, 1);
    collect(3500, 100, "D");
    check("D_throughput", last_cycles, 3500);
    tick(1);
    check("D_done", done, 1);
    check("D_rd_addr_end", rd_addr, 3499);

    // 2x2x1 with zero border
    bram[0] = 8'd5; bram[1] = 8'd6; bram[2] = 8'd7; bram[3] = 8'd8;
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd6, 8'd0,
              8'd0, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    pulse_start(2, 2, 1, 1);
    check("E_rd_addr0", rd_addr, 0);
    collect(16, 100, "E");
    check("E_throughput", last_cycles, 16);
    tick(1);
    check("E_done", done, 1);
    check("E_rd_addr_end", rd_addr, 3);
    for (int a = 0; a < 4; a++) bram[a] = 8'(a);

    // Start while busy is ignored, then reset in the middle of a frame
    pulse_start(4, 3, 2, 0);
    tick(8);
    pulse_start(0, 3, 2, 0);
    check("F_busy_start_no_err", cfg_err, 0);
    check("F_busy_mid", busy, 1);
    rst_n = 1'b0;
    tick(1);
    check("F_rst_valid", out_valid, 0);
    check("F_rst_busy", busy, 1);
    check("F_rst_rd_addr", rd_addr, 0);
    rst_n = 1'b1;
    tick(CLEAR_CYCLES + 4);
    check("F_idle_busy", busy, 0);
    exp_ramp(24);
    pulse_start(4, 3, 2, 0);
    check("F_rd_addr0", rd_addr, 0);
    check("F_busy", busy, 1);
    collect(24, 100, "F");
    tick(1);
    check("F_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_rearrange_reader.md
Name: psum_rearrange_reader

Overview:
- Read-side master of the psum rearrange buffer.
- After a start pulse, generates buffer read addresses in channel-major raster order and absorbs the BRAM's 1-cycle read latency.
- Optionally inserts a zero-padding border.
- Emits the next layer's ifmap as a valid/ready byte stream toward the PE-array ifmap GLB loader.

Parameters:
ADDR_W, 12, buffer address width
DATA_W, 8, signed element width
BUFFER_DEPTH, 3500, valid addresses 0..BUFFER_DEPTH-1
CLEAR_CYCLES, 4096, cycles the buffer needs after reset to zero itself
FIFO_DEPTH, 2, output skid FIFO entries (fixed at 2)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low (reset==0 resets on the clock edge)
start  in  1  one-cycle request; sampled only in IDLE
cfg_width  in  6  ifmap width W, 1..32
cfg_height  in  6  ifmap height H, 1..32
cfg_channels  in  4  channel count C, 1..8
cfg_pad_en  in  1  1 = emit one-element zero border per channel
rd_addr  out  ADDR_W  buffer read address, to the buffer's read_addr
rd_data  in  DATA_W  buffer data_out; valid the cycle after rd_addr is presented
out_data  out  DATA_W  stream element (signed)
out_valid  out  1  element available
out_ready  in  1  consumer accepts when out_valid & out_ready
out_last  out  1  marks the final element of the frame
busy  out  1  high in CLEAR_WAIT, RUN and DRAIN
done  out  1  one-cycle pulse after the last element is accepted
cfg_err  out  1  one-cycle pulse when start is rejected for bad config

Behaviour:
- Reset values: rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=1, done=0, cfg_err=0. FIFO is emptied and the state is CLEAR_WAIT.
- CLEAR_WAIT:
  - Counts CLEAR_CYCLES cycles from reset release, then moves to IDLE.
  - start is ignored in this state; no cfg_err is raised.
- IDLE:
  - On start, latches the cfg_* inputs.
  - If W==0, H==0, C==0, or C*H*W > BUFFER_DEPTH: pulses cfg_err the next cycle and stays in IDLE.
  - Otherwise moves to RUN.
- RUN:
  - Iterates c=0..C-1, then y, then x.
  - Padded extents: Hp = H+2p, Wp = W+2p, where p = cfg_pad_en.
  - Each slot is either a read or a pad:
    - Read slot: rd_addr = c*H*W + (y-p)*W + (x-p). Computed incrementally (channel base += H*W, row base += W); no multiplier in the loop.
    - Pad slot (y<p, y>=H+p, x<p, or x>=W+p): no read is issued; a zero is tagged into the same 1-cycle pipeline so order is preserved.
  - A slot is issued only if FIFO occupancy plus in-flight slots < 2.
  - With out_ready held high, throughput is 1 element per cycle.
  - After the last slot is issued, moves to DRAIN.
- DRAIN: waits until the FIFO is empty and the last element is accepted, then pulses done and returns to IDLE.
- Latency: start sampled at edge k → first rd_addr presented in cycle k+1 → rd_data captured at the end of cycle k+2 → out_valid high in cycle k+3.
- Stream rules:
  - out_data and out_last are stable while out_valid & ~out_ready.
  - out_last is high exactly on element number C*Hp*Wp.
  - No element is dropped or duplicated under any out_ready pattern.
- Simultaneous push and pop with a full FIFO is legal; occupancy is unchanged.
- start while busy is ignored, with no cfg_err.
- Reset asserted mid-RUN: all state is cleared and the block returns to CLEAR_WAIT, because the buffer re-clears on reset too.
- rd_addr holds its last value when no read is issued.

Decomposition:
- Shared package psum_rearrange_pkg holds ADDR_W, DATA_W, BUFFER_DEPTH, CLEAR_CYCLES and the state encoding (CLEAR_WAIT, IDLE, RUN, DRAIN). The writer side uses the same package.
- One sub-module: psum_reader_skid_fifo, a 2-entry FIFO carrying {last, data} with push/pop and a count output.

Test Plan:
- Reset, then start in cycle 100 → no cfg_err and no out_valid. Start in cycle CLEAR_CYCLES+5 → RUN; rd_addr=0 one cycle later.
- W=4, H=3, C=2, pad off, out_ready=1, buffer preloaded with addr&0x7F → 24 elements 0..23 on consecutive cycles; out_last on the 24th; done one cycle after.
- W=2, H=2, C=1, pad on, data 5,6,7,8 → 16 elements: 0,0,0,0, 0,5,6,0, 0,7,8,0, 0,0,0,0; only 4 reads issued (addr 0..3).
- Same frame as scenario 2 with out_ready random at 30% → identical sequence, no loss or duplicates; out_data stable while stalled.
- Start with C=8, H=24, W=24 (4608 > 3500) → cfg_err pulse, busy stays 0, no reads. Start with W=0 → cfg_err.
- reset=0 in the middle of the scenario-2 frame → out_valid=0 next cycle, busy=1; a fresh start after CLEAR_CYCLES restarts from rd_addr=0.
